// File: rtl/miriscv_dmem_arb_if.sv
`default_nettype none
// ============================================================================
// miriscv_dmem_arb_if : bus bundle for the two-master data-memory arbiter
// Revision: 1.0
// ============================================================================
interface miriscv_dmem_arb_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [3:0]  m0_be_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;

  logic        mem_ready_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  // Environment side: both requesting masters plus the data RAM.
  modport master (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output mem_ready_i, mem_rdata_i,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  mem_ready_i, mem_rdata_i,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/miriscv_dmem_arb.sv
`default_nettype none
// ============================================================================
// miriscv_dmem_arb : shares one data-memory port between LSU (m0) and DMA (m1)
// Revision: 1.0
// ============================================================================
module miriscv_dmem_arb #(
  parameter int unsigned PRIO_MODE  = 0,
  parameter int unsigned STARVE_MAX = 8
) (
  input wire clk_i,
  input wire resetn_i,
  miriscv_dmem_arb_if.slave bus
);

  localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

  logic       r_rr;
  logic [7:0] r_starve;
  logic       r_rsp_valid;
  logic       r_rsp_owner;

  logic w_req;
  logic w_win;
  logic w_accept;
  logic w_gnt1;

  always_comb begin
    w_win = bus.m1_req_i;
    if (bus.m0_req_i && bus.m1_req_i) begin
      if (PRIO_MODE == 0) begin
        w_win = r_rr;
      end else begin
        w_win = (r_starve == c_starve_max);
      end
    end
  end

  assign w_req    = bus.m0_req_i | bus.m1_req_i;
  assign w_accept = w_req & bus.mem_ready_i;
  assign w_gnt1   = w_accept & w_win;

  assign bus.m0_gnt_o = w_accept & ~w_win;
  assign bus.m1_gnt_o = w_gnt1;

  // Payload follows the winner even while memory stalls.
  assign bus.mem_req_o   = w_req;
  assign bus.mem_we_o    = w_req & (w_win ? bus.m1_we_i : bus.m0_we_i);
  assign bus.mem_be_o    = w_req ? (w_win ? bus.m1_be_i : bus.m0_be_i) : 4'b0000;
  assign bus.mem_addr_o  = w_win ? bus.m1_addr_i  : bus.m0_addr_i;
  assign bus.mem_wdata_o = w_win ? bus.m1_wdata_i : bus.m0_wdata_i;

  assign bus.m0_rvalid_o = r_rsp_valid & ~r_rsp_owner;
  assign bus.m1_rvalid_o = r_rsp_valid &  r_rsp_owner;
  assign bus.m0_rdata_o  = bus.m0_rvalid_o ? bus.mem_rdata_i : 32'h0;
  assign bus.m1_rdata_o  = bus.m1_rvalid_o ? bus.mem_rdata_i : 32'h0;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rr        <= 1'b0;
      r_starve    <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr <= ~w_win;
      end
      // Counts refused m1 cycles, including memory stalls.
      if (PRIO_MODE != 0) begin
        if (!bus.m1_req_i || w_gnt1) begin
          r_starve <= 8'd0;
        end else if (r_starve != c_starve_max) begin
          r_starve <= r_starve + 8'd1;
        end
      end
      r_rsp_valid <= w_accept;
      r_rsp_owner <= w_win;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_dmem_arb.sv
`default_nettype none
// ============================================================================
// tb_miriscv_dmem_arb : directed bench for round-robin and fixed-priority arbiters
// Revision: 1.0
// ============================================================================
module tb_miriscv_dmem_arb;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  miriscv_dmem_arb_if b0 ();
  miriscv_dmem_arb_if b1 ();

  miriscv_dmem_arb #(.PRIO_MODE(0), .STARVE_MAX(8)) dut_rr (
    .clk_i(clk), .resetn_i(resetn), .bus(b0.slave));
  miriscv_dmem_arb #(.PRIO_MODE(1), .STARVE_MAX(3)) dut_fx (
    .clk_i(clk), .resetn_i(resetn), .bus(b1.slave));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    b0.m0_req_i = 0; b0.m0_we_i = 0; b0.m0_be_i = 0; b0.m0_addr_i = 0; b0.m0_wdata_i = 0;
    b0.m1_req_i = 0; b0.m1_we_i = 0; b0.m1_be_i = 0; b0.m1_addr_i = 0; b0.m1_wdata_i = 0;
    b0.mem_ready_i = 1; b0.mem_rdata_i = 0;
    b1.m0_req_i = 0; b1.m0_we_i = 0; b1.m0_be_i = 0; b1.m0_addr_i = 0; b1.m0_wdata_i = 0;
    b1.m1_req_i = 0; b1.m1_we_i = 0; b1.m1_be_i = 0; b1.m1_addr_i = 0; b1.m1_wdata_i = 0;
    b1.mem_ready_i = 1; b1.mem_rdata_i = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle();
    @(negedge clk);
    n_checks++; if (b0.m0_gnt_o !== 1'b0 || b0.m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b want 00", b0.m1_gnt_o, b0.m0_gnt_o); end
    n_checks++; if (b0.m0_rvalid_o !== 1'b0 || b0.m1_rvalid_o !== 1'b0 || b1.m0_rvalid_o !== 1'b0 || b1.m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got nonzero want 0"); end
    n_checks++; if (b0.m0_rdata_o !== 32'h0 || b0.m1_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0", b0.m0_rdata_o, b0.m1_rdata_o); end
    n_checks++; if (b0.mem_req_o !== 1'b0 || b0.mem_we_o !== 1'b0 || b0.mem_be_o !== 4'b0) begin n_fail++; $display("FAIL reset_idle_payload: got req=%b we=%b be=%b want 0", b0.mem_req_o, b0.mem_we_o, b0.mem_be_o); end
    b0.m0_req_i = 1;
    #1;
    n_checks++; if (b0.m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL reset_gnt_follows: got %b want 1", b0.m0_gnt_o); end
    b0.m0_req_i = 0;
    next_cycle();
    resetn = 1;
    @(negedge clk);
    n_checks++; if (b0.m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_rvalid: got %b want 0", b0.m0_rvalid_o); end
    n_checks++; if (dut_fx.r_starve !== 8'd0) begin n_fail++; $display("FAIL reset_starve: got %0d want 0", dut_fx.r_starve); end
    next_cycle();
  endtask

  task automatic test_rr_alternate();
    logic e0, e1, ev0, ev1;
    b0.m0_addr_i = 32'h100; b0.m1_addr_i = 32'h200;
    b0.m0_req_i = 1; b0.m1_req_i = 1;
    for (int i = 0; i <= 6; i++) begin
      if (i == 6) begin b0.m0_req_i = 0; b0.m1_req_i = 0; end
      b0.mem_rdata_i = 32'hA000_0000 + i;
      e0  = (i < 6) && (i % 2 == 0);
      e1  = (i < 6) && (i % 2 == 1);
      ev0 = (i > 0) && ((i - 1) % 2 == 0);
      ev1 = (i > 0) && ((i - 1) % 2 == 1);
      @(negedge clk);
      n_checks++; if (b0.m0_gnt_o !== e0 || b0.m1_gnt_o !== e1) begin n_fail++; $display("FAIL rr_gnt cyc%0d: got %b%b want %b%b", i, b0.m1_gnt_o, b0.m0_gnt_o, e1, e0); end
      n_checks++; if (b0.m0_rvalid_o !== ev0 || b0.m1_rvalid_o !== ev1) begin n_fail++; $display("FAIL rr_rvalid cyc%0d: got %b%b want %b%b", i, b0.m1_rvalid_o, b0.m0_rvalid_o, ev1, ev0); end
      if (i < 6) begin
        n_checks++; if (b0.mem_addr_o !== (e1 ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL rr_addr cyc%0d: got %h want %h", i, b0.mem_addr_o, e1 ? 32'h200 : 32'h100); end
      end
      if (ev1) begin
        n_checks++; if (b0.m1_rdata_o !== 32'hA000_0000 + i || b0.m0_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rr_rdata1 cyc%0d: got %h/%h want %h/0", i, b0.m1_rdata_o, b0.m0_rdata_o, 32'hA000_0000 + i); end
      end
      if (ev0) begin
        n_checks++; if (b0.m0_rdata_o !== 32'hA000_0000 + i || b0.m1_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rr_rdata0 cyc%0d: got %h/%h want %h/0", i, b0.m0_rdata_o, b0.m1_rdata_o, 32'hA000_0000 + i); end
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_single_read();
    b0.m0_req_i = 1; b0.m0_we_i = 0; b0.m0_be_i = 4'hF; b0.m0_addr_i = 32'h10;
    @(negedge clk);
    n_checks++; if (b0.m0_gnt_o !== 1'b1 || b0.m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL sr_gnt: got %b%b want 01", b0.m1_gnt_o, b0.m0_gnt_o); end
    n_checks++; if (b0.mem_req_o !== 1'b1 || b0.mem_addr_o !== 32'h10 || b0.mem_we_o !== 1'b0 || b0.mem_be_o !== 4'hF) begin n_fail++; $display("FAIL sr_payload: got req=%b addr=%h we=%b be=%h want 1/10/0/f", b0.mem_req_o, b0.mem_addr_o, b0.mem_we_o, b0.mem_be_o); end
    n_checks++; if (b0.m0_rvalid_o !== 1'b0 || b0.m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL sr_rvalid_early: got %b%b want 00", b0.m1_rvalid_o, b0.m0_rvalid_o); end
    next_cycle();
    b0.m0_req_i = 0; b0.mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (b0.m0_rvalid_o !== 1'b1 || b0.m0_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_resp: got v=%b d=%h want 1/deadbeef", b0.m0_rvalid_o, b0.m0_rdata_o); end
    n_checks++; if (b0.m1_rvalid_o !== 1'b0 || b0.m1_rdata_o !== 32'h0) begin n_fail++; $display("FAIL sr_m1_quiet: got v=%b d=%h want 0/0", b0.m1_rvalid_o, b0.m1_rdata_o); end
    n_checks++; if (b0.mem_req_o !== 1'b0 || b0.mem_be_o !== 4'h0 || b0.m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL sr_idle: got req=%b be=%h gnt=%b want 0", b0.mem_req_o, b0.mem_be_o, b0.m0_gnt_o); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (b0.m0_rvalid_o !== 1'b0 || b0.m0_rdata_o !== 32'h0) begin n_fail++; $display("FAIL sr_after: got v=%b d=%h want 0/0", b0.m0_rvalid_o, b0.m0_rdata_o); end
    next_cycle();
    idle();
  endtask

  task automatic test_starve();
    logic       e1;
    logic [7:0] es;
    b1.m0_req_i = 1; b1.m1_req_i = 1;
    for (int i = 0; i <= 8; i++) begin
      if (i == 8) begin b1.m0_req_i = 0; b1.m1_req_i = 0; end
      e1 = (i < 8) && (i % 4 == 3);
      es = (i < 8) ? 8'(i % 4) : 8'd0;
      @(negedge clk);
      n_checks++; if (b1.m1_gnt_o !== e1 || b1.m0_gnt_o !== ((i < 8) && !e1)) begin n_fail++; $display("FAIL fx_gnt cyc%0d: got %b%b want m1=%b", i, b1.m1_gnt_o, b1.m0_gnt_o, e1); end
      n_checks++; if (dut_fx.r_starve !== es) begin n_fail++; $display("FAIL fx_starve cyc%0d: got %0d want %0d", i, dut_fx.r_starve, es); end
      if (i > 0) begin
        n_checks++; if (b1.m1_rvalid_o !== ((i - 1) % 4 == 3) || b1.m0_rvalid_o !== ((i - 1) % 4 != 3)) begin n_fail++; $display("FAIL fx_rvalid cyc%0d: got %b%b", i, b1.m1_rvalid_o, b1.m0_rvalid_o); end
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_ready_stall();
    b0.m1_req_i = 1; b0.m1_we_i = 1; b0.m1_be_i = 4'b1100; b0.m1_addr_i = 32'h40; b0.m1_wdata_i = 32'h12345678;
    b1.m1_req_i = 1; b1.m1_we_i = 1; b1.m1_be_i = 4'b1100; b1.m1_addr_i = 32'h40; b1.m1_wdata_i = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      b0.mem_ready_i = (i == 2); b1.mem_ready_i = (i == 2);
      @(negedge clk);
      n_checks++; if (b0.m1_gnt_o !== (i == 2) || b0.m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL st_gnt cyc%0d: got %b%b want m1=%b", i, b0.m1_gnt_o, b0.m0_gnt_o, i == 2); end
      n_checks++; if (b0.mem_req_o !== 1'b1 || b0.mem_we_o !== 1'b1 || b0.mem_be_o !== 4'b1100 || b0.mem_wdata_o !== 32'h12345678) begin n_fail++; $display("FAIL st_payload cyc%0d: got we=%b be=%b wd=%h", i, b0.mem_we_o, b0.mem_be_o, b0.mem_wdata_o); end
      n_checks++; if (b0.m0_rvalid_o !== 1'b0 || b0.m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL st_rvalid cyc%0d: got %b%b want 00", i, b0.m1_rvalid_o, b0.m0_rvalid_o); end
      n_checks++; if (dut_fx.r_starve !== 8'(i) || b1.m1_gnt_o !== (i == 2)) begin n_fail++; $display("FAIL st_starve cyc%0d: got %0d gnt=%b want %0d", i, dut_fx.r_starve, b1.m1_gnt_o, i); end
      next_cycle();
    end
    idle();
    @(negedge clk);
    n_checks++; if (b0.m1_rvalid_o !== 1'b1 || b0.m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL st_resp: got %b%b want 10", b0.m1_rvalid_o, b0.m0_rvalid_o); end
    n_checks++; if (b1.m1_rvalid_o !== 1'b1 || dut_fx.r_starve !== 8'd0) begin n_fail++; $display("FAIL st_fx_resp: got v=%b starve=%0d want 1/0", b1.m1_rvalid_o, dut_fx.r_starve); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    b0.m0_req_i = 1; b0.m0_addr_i = 32'h20;
    b1.m1_req_i = 1; b1.mem_ready_i = 0;
    @(negedge clk);
    n_checks++; if (b0.m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b want 1", b0.m0_gnt_o); end
    next_cycle();
    b0.m0_req_i = 0; b0.mem_rdata_i = 32'h5555AAAA;
    resetn = 0;
    @(negedge clk);
    n_checks++; if (b0.m0_rvalid_o !== 1'b0 || b0.m0_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rm_dropped: got v=%b d=%h want 0/0", b0.m0_rvalid_o, b0.m0_rdata_o); end
    n_checks++; if (dut_fx.r_starve !== 8'd0) begin n_fail++; $display("FAIL rm_starve: got %0d want 0", dut_fx.r_starve); end
    next_cycle();
    resetn = 1;
    b0.m0_req_i = 1; b0.m1_req_i = 1; b0.m1_addr_i = 32'h24;
    @(negedge clk);
    n_checks++; if (b0.m0_gnt_o !== 1'b1 || b0.m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rm_rr_reset: got %b%b want 01", b0.m1_gnt_o, b0.m0_gnt_o); end
    n_checks++; if (b0.m0_rvalid_o !== 1'b0 || b0.m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rm_no_rvalid: got %b%b want 00", b0.m1_rvalid_o, b0.m0_rvalid_o); end
    next_cycle();
    idle();
    b0.mem_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    n_checks++; if (b0.m0_rvalid_o !== 1'b1 || b0.m0_rdata_o !== 32'h0BADF00D) begin n_fail++; $display("FAIL rm_post_resp: got v=%b d=%h want 1/0badf00d", b0.m0_rvalid_o, b0.m0_rdata_o); end
    next_cycle();
    idle();
  endtask

  task automatic test_back_to_back();
    b0.m1_we_i = 0; b0.m1_be_i = 4'hF;
    for (int i = 0; i <= 5; i++) begin
      b0.m1_req_i = (i < 4);
      b0.m1_addr_i = 32'h300 + 32'(4 * i);
      b0.mem_rdata_i = 32'hB000_0000 | 32'(i);
      @(negedge clk);
      n_checks++; if (b0.m1_gnt_o !== (i < 4)) begin n_fail++; $display("FAIL b2b_gnt cyc%0d: got %b want %b", i, b0.m1_gnt_o, i < 4); end
      if (i < 4) begin
        n_checks++; if (b0.mem_addr_o !== 32'h300 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_addr cyc%0d: got %h want %h", i, b0.mem_addr_o, 32'h300 + 32'(4 * i)); end
      end
      n_checks++; if (b0.m1_rvalid_o !== (i >= 1 && i <= 4)) begin n_fail++; $display("FAIL b2b_rvalid cyc%0d: got %b want %b", i, b0.m1_rvalid_o, i >= 1 && i <= 4); end
      n_checks++; if (b0.m1_rdata_o !== ((i >= 1 && i <= 4) ? (32'hB000_0000 | 32'(i)) : 32'h0)) begin n_fail++; $display("FAIL b2b_rdata cyc%0d: got %h", i, b0.m1_rdata_o); end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_rr_alternate();
    test_single_read();
    test_starve();
    test_ready_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
